// File: rtl/mac_vector_if.sv
// mac_vector_if: valid/ready term stream in, dot-product result stream out.
interface mac_vector_if #(
    parameter int DATA_W  = 8,
    parameter int OUT_W   = 16,
    parameter int VEC_LEN = 9
);
    localparam int IW = $clog2(VEC_LEN) + 1;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] a_in;
    logic signed [DATA_W-1:0] b_in;
    logic signed [OUT_W-1:0]  init_in;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [OUT_W-1:0]  result;
    logic                     sat_flag;
    logic [IW-1:0]            term_idx;
    modport master (output in_valid, a_in, b_in, init_in, out_ready,
                    input  in_ready, out_valid, result, sat_flag, term_idx);
    modport slave  (input  in_valid, a_in, b_in, init_in, out_ready,
                    output in_ready, out_valid, result, sat_flag, term_idx);
endinterface

// File: rtl/mac_vector_engine.sv
// mac_vector_engine: pipelined signed dot product (multiply, accumulate, output register).
// MAC_SATURATE_EN clamps the final sum to OUT_W and raises sat_flag; otherwise the sum wraps.
module mac_vector_engine #(
    parameter int DATA_W  = 8,
    parameter int VEC_LEN = 9,
    parameter int OUT_W   = 16,
    parameter int ACC_W   = 2*DATA_W + $clog2(VEC_LEN) + 1
) (
    input logic        clk,
    input logic        rst_n,
    input logic        clear,
    mac_vector_if.slave bus
);
    localparam int IW = $clog2(VEC_LEN) + 1;
    localparam int PW = 2*DATA_W;
    localparam logic [IW-1:0] LAST_IDX = IW'(VEC_LEN - 1);

    logic                    stall;
    logic                    s1_valid, s1_first, s1_last, s2_last;
    logic signed [PW-1:0]    s1_prod;
    logic signed [OUT_W-1:0] s1_init, res_n;
    logic signed [ACC_W-1:0] acc, acc_n;
    logic                    sat_n;
    logic [IW-1:0]           idx;

    assign stall        = bus.out_valid & ~bus.out_ready;
    assign bus.in_ready = ~stall;
    assign bus.term_idx = idx;
    assign acc_n        = (s1_first ? ACC_W'(s1_init) : acc) + ACC_W'(s1_prod);

    // The output stage narrows the finished sum held in acc.
`ifdef MAC_SATURATE_EN
    localparam logic signed [ACC_W-1:0] MAXV = ACC_W'({(OUT_W-1){1'b1}});
    localparam logic signed [ACC_W-1:0] MINV = ~MAXV;
    always_comb begin
        sat_n = (acc > MAXV) | (acc < MINV);
        res_n = acc > MAXV ? MAXV[OUT_W-1:0] : acc < MINV ? MINV[OUT_W-1:0] : acc[OUT_W-1:0];
    end
`else
    always_comb begin
        sat_n = 1'b0;
        res_n = acc[OUT_W-1:0];
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx           <= '0;
            s1_valid      <= 1'b0;
            s1_first      <= 1'b0;
            s1_last       <= 1'b0;
            s1_prod       <= '0;
            s1_init       <= '0;
            s2_last       <= 1'b0;
            acc           <= '0;
            bus.out_valid <= 1'b0;
            bus.result    <= '0;
            bus.sat_flag  <= 1'b0;
        end else if (clear) begin
            idx           <= '0;
            s1_valid      <= 1'b0;
            s2_last       <= 1'b0;
            acc           <= '0;
            bus.out_valid <= 1'b0;
            bus.result    <= '0;
            bus.sat_flag  <= 1'b0;
        end else if (!stall) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_prod  <= PW'(bus.a_in) * PW'(bus.b_in);
                s1_first <= idx == '0;
                s1_last  <= idx == LAST_IDX;
                if (idx == '0) s1_init <= bus.init_in;
                idx <= idx == LAST_IDX ? '0 : idx + IW'(1);
            end
            s2_last <= s1_valid & s1_last;
            if (s1_valid) acc <= acc_n;
            // A completing vector reloads the output in the same cycle the old result drains.
            if (s2_last) begin
                bus.out_valid <= 1'b1;
                bus.result    <= res_n;
                bus.sat_flag  <= sat_n;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mac_vector_engine.sv
// tb_mac_vector_engine: table vectors, hand sequences and random traffic against a dot-product scoreboard.
module tb_mac_vector_engine;
    localparam int DW = 8, OW = 16, VL = 4;

    logic clk = 0, rst_n = 0, clear = 0;
    always #5 clk = ~clk;

    mac_vector_if #(.DATA_W(DW), .OUT_W(OW), .VEC_LEN(VL)) b0();
    mac_vector_if #(.DATA_W(DW), .OUT_W(OW), .VEC_LEN(1))  b1();

    mac_vector_engine #(.DATA_W(DW), .VEC_LEN(VL), .OUT_W(OW)) dut0 (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(b0));
    mac_vector_engine #(.DATA_W(DW), .VEC_LEN(1),  .OUT_W(OW)) dut1 (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(b1));

    typedef struct {longint res; bit sat;} exp_t;
    typedef struct {longint init; longint a[4]; longint b[4]; longint res; bit sat;} vec_t;

    int n_checks = 0, n_fail = 0, cyc = 0;
    exp_t q0[$], q1[$];
    int outcyc[$];
    longint cur_sum;
    int cur_n = 0;
    bit prev_stall = 0;
    logic signed [OW-1:0] prev_res;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic exp_t narrow(input longint s);
        exp_t e;
`ifdef MAC_SATURATE_EN
        longint mx;
        mx = (64'sd1 <<< (OW-1)) - 1;
        e.sat = (s > mx) || (s < -mx-1);
        e.res = s > mx ? mx : (s < -mx-1 ? -mx-1 : s);
`else
        logic signed [OW-1:0] w;
        w = s[OW-1:0];
        e.res = w;
        e.sat = 0;
`endif
        return e;
    endfunction

    // Scoreboard: whole vectors are summed with plain arithmetic and queued.
    always @(negedge clk) begin
        if (!rst_n || clear) begin
            q0.delete();
            cur_n = 0;
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", b0.out_valid, 1);
                check("hold_result", b0.result, prev_res);
            end
            if (b0.out_valid) outcyc.push_back(cyc);
            if (b0.out_valid && b0.out_ready) begin
                if (q0.size() == 0) check("spurious_result", 1, 0);
                else begin
                    exp_t e;
                    e = q0.pop_front();
                    check("sb_result", b0.result, e.res);
                    check("sb_sat", b0.sat_flag, e.sat);
                end
            end
            if (b0.in_valid && b0.in_ready) begin
                if (cur_n == 0) cur_sum = b0.init_in;
                cur_sum += longint'(b0.a_in) * longint'(b0.b_in);
                cur_n++;
                if (cur_n == VL) begin
                    q0.push_back(narrow(cur_sum));
                    cur_n = 0;
                end
            end
            prev_stall = b0.out_valid && !b0.out_ready;
            prev_res = b0.result;
        end
    end

    always @(negedge clk) begin
        if (!rst_n || clear) q1.delete();
        else begin
            if (b1.out_valid && b1.out_ready) begin
                if (q1.size() == 0) check("v1_spurious", 1, 0);
                else begin
                    exp_t e;
                    e = q1.pop_front();
                    check("v1_result", b1.result, e.res);
                    check("v1_sat", b1.sat_flag, e.sat);
                end
            end
            if (b1.in_valid && b1.in_ready)
                q1.push_back(narrow(longint'(b1.init_in) + longint'(b1.a_in) * longint'(b1.b_in)));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input longint a, input longint b, input longint init, output int at);
        bit ok;
        int n;
        ok = 0;
        n = 0;
        b0.in_valid = 1;
        b0.a_in = DW'(a);
        b0.b_in = DW'(b);
        b0.init_in = OW'(init);
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = b0.in_ready;
            step();
            n++;
        end
        at = cyc;
        b0.in_valid = 0;
        if (!ok) check("accept_timeout", 0, 1);
    endtask

    task automatic wait_out(output int at);
        int n;
        n = 0;
        @(negedge clk);
        while (!b0.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        at = cyc;
        if (!b0.out_valid) check("out_timeout", 0, 1);
    endtask

    function automatic longint rnd(input int w);
        return longint'($urandom_range(0, (1 << w) - 1)) - (64'sd1 <<< (w-1));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[6];
        int at, oc, first;
        int lastq[$];
        tbl[0] = '{10,   '{1, 2, 3, 4},         '{5, 6, 7, 8},         80,     0};
        tbl[1] = '{0,    '{-128, -128, -128, -128}, '{-128, -128, -128, -128}, 0, 0};
        tbl[2] = '{-32768, '{-128, -128, -128, -128}, '{127, 127, 127, 127}, -32256, 0};
        tbl[3] = '{-5,   '{3, -2, 0, 7},        '{4, 4, 9, -1},        -8,     0};
        tbl[4] = '{32767, '{0, 0, 0, 1},        '{0, 0, 0, 1},         -32768, 0};
        tbl[5] = '{100,  '{127, 127, -128, -128}, '{127, -128, 127, -128}, 101, 0};
`ifdef MAC_SATURATE_EN
        tbl[1].res = 32767;  tbl[1].sat = 1;
        tbl[2].res = -32768; tbl[2].sat = 1;
        tbl[4].res = 32767;  tbl[4].sat = 1;
`endif
        b0.in_valid = 0; b0.a_in = 0; b0.b_in = 0; b0.init_in = 0; b0.out_ready = 1;
        b1.in_valid = 0; b1.a_in = 0; b1.b_in = 0; b1.init_in = 0; b1.out_ready = 1;
        repeat (2) step();
        check("rst_out_valid", b0.out_valid, 0);
        check("rst_result", b0.result, 0);
        check("rst_sat", b0.sat_flag, 0);
        check("rst_term_idx", b0.term_idx, 0);
        check("rst_v1_out_valid", b1.out_valid, 0);
        @(negedge clk);
        rst_n = 1;
        step();
        check("in_ready_after_reset", b0.in_ready, 1);

        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 4; k++) begin
                put(tbl[i].a[k], tbl[i].b[k], tbl[i].init, at);
                check($sformatf("tbl%0d_term_idx", i), b0.term_idx, (k + 1) % 4);
            end
            wait_out(oc);
            check($sformatf("tbl%0d_latency", i), oc - at, 2);
            check($sformatf("tbl%0d_result", i), b0.result, tbl[i].res);
            check($sformatf("tbl%0d_sat", i), b0.sat_flag, tbl[i].sat);
            step();
        end

        // Backpressure: second vector streams in while the first result is held.
        b0.out_ready = 0;
        fork
            begin
                int t;
                for (int k = 0; k < 4; k++) put(tbl[0].a[k], tbl[0].b[k], 10, t);
                for (int k = 0; k < 4; k++) put(k % 2 ? 2*k : -k, 5, 3, t);
            end
            begin
                int t;
                wait_out(t);
                check("bp_result", b0.result, 80);
                repeat (5) begin
                    @(negedge clk);
                    check("bp_in_ready", b0.in_ready, 0);
                    check("bp_stable", b0.result, 80);
                end
                step();
                b0.out_ready = 1;
            end
        join
        repeat (10) step();
        check("bp_drain", q0.size(), 0);

        outcyc.delete();
        for (int i = 0; i < 12; i++) begin
            put(rnd(DW), rnd(DW), rnd(OW), at);
            if (i == 0) first = at;
            if (i % 4 == 3) lastq.push_back(at);
        end
        repeat (6) step();
        check("b2b_input_span", lastq[2] - first, 11);
        check("b2b_count", outcyc.size(), 3);
        for (int k = 0; k < 3; k++)
            if (k < outcyc.size()) check($sformatf("b2b_out_cycle%0d", k), outcyc[k], lastq[k] + 2);
        check("b2b_drain", q0.size(), 0);

        repeat (400) begin
            b0.in_valid = $urandom_range(0, 1);
            b0.a_in = DW'(rnd(DW));
            b0.b_in = DW'(rnd(DW));
            b0.init_in = OW'(rnd(OW));
            b0.out_ready = $urandom_range(0, 3) != 0;
            step();
        end
        b0.in_valid = 0;
        b0.out_ready = 1;
        repeat (8) step();
        check("rand_drain", q0.size(), 0);

        clear = 1;
        step();
        clear = 0;
        put(5, 5, 100, at);
        put(6, 6, 100, at);
        check("pre_clear_idx", b0.term_idx, 2);
        clear = 1;
        b0.in_valid = 1;
        b0.a_in = 9;
        b0.b_in = 9;
        step();
        clear = 0;
        b0.in_valid = 0;
        check("clear_term_idx", b0.term_idx, 0);
        check("clear_out_valid", b0.out_valid, 0);
        for (int k = 0; k < 4; k++) put(1, 2, 0, at);
        wait_out(oc);
        check("clear_result", b0.result, 8);
        repeat (6) step();
        check("clear_drain", q0.size(), 0);

        for (int k = 0; k < 3; k++) put(7, 7, 50, at);
        #2;
        rst_n = 0;
        #1;
        check("mid_rst_term_idx", b0.term_idx, 0);
        check("mid_rst_out_valid", b0.out_valid, 0);
        check("mid_rst_result", b0.result, 0);
        check("mid_rst_sat", b0.sat_flag, 0);
        step();
        rst_n = 1;
        for (int k = 0; k < 4; k++) put(2, 3, -7, at);
        wait_out(oc);
        check("post_rst_result", b0.result, 17);
        repeat (6) step();
        check("post_rst_drain", q0.size(), 0);

        b1.in_valid = 1;
        b1.init_in = 10; b1.a_in = 3; b1.b_in = -4;
        step();
        for (int i = 0; i < 8; i++) begin
            b1.init_in = OW'(rnd(OW));
            b1.a_in = DW'(rnd(DW));
            b1.b_in = DW'(rnd(DW));
            step();
        end
        b1.in_valid = 0;
        repeat (4) step();
        check("v1_drain", q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
